cmd_framer: RTL and testbench



---
 rtl/comm_pkg.sv | 27 ++
 rtl/cmd_framer_if.sv | 38 +++
 rtl/frame_timer.sv | 46 ++++
 rtl/cmd_framer.sv | 159 +++++++++++++++
 tb/tb_cmd_framer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/comm_pkg.sv
// ----------------------------------------------------------------------------
// comm_pkg
// Shared widths and state encodings for the logic-analyzer serial link
// command framer.
//   CMD_W      : width of an assembled command (two bytes)
//   BYTE_W     : width of one UART byte
//   rx_state_t : receive-side framing states
//   tx_state_t : response-transmit states
// ----------------------------------------------------------------------------
package comm_pkg;

  localparam int CMD_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    WAIT_LOW  = 2'd1,
    FULL      = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/cmd_framer_if.sv
// ----------------------------------------------------------------------------
// cmd_framer_if
// Bundles the UART receive/transmit handshakes and the dispatcher
// command/response handshakes seen by cmd_framer.
//   slave  : view used by cmd_framer (drives clr_rx_rdy, cmd, cmd_rdy,
//            timeout, trmt, tx_data, tx_busy, resp_sent)
//   master : view used by the surrounding UART/dispatcher (drives rx_rdy,
//            rx_data, clr_cmd_rdy, resp, send_resp, tx_done)
// ----------------------------------------------------------------------------
interface cmd_framer_if;
  import comm_pkg::*;

  logic              rx_rdy;
  logic [BYTE_W-1:0] rx_data;
  logic              clr_rx_rdy;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_rdy;
  logic              clr_cmd_rdy;
  logic              timeout;
  logic [BYTE_W-1:0] resp;
  logic              send_resp;
  logic              trmt;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_done;
  logic              tx_busy;
  logic              resp_sent;

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, timeout, trmt, tx_data, tx_busy, resp_sent
  );

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, timeout, trmt, tx_data, tx_busy, resp_sent
  );

endinterface

// File: rtl/frame_timer.sv
// ----------------------------------------------------------------------------
// frame_timer
// Inter-byte timer for the command framer. Counts cycles while en is high
// and flags the last allowed cycle of the wait.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   clr     : restart the count at zero (wins over en)
//   en      : count this cycle
//   expired : high while counting and the count equals TIMEOUT_CYCLES-1
// ----------------------------------------------------------------------------
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int             W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  // The owner leaves its waiting state on the cycle expired is seen, so the
  // count never exceeds TIMEOUT_CYCLES and the width cannot wrap.
  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  // Gated with en so a value left over from an earlier wait cannot leak out.
  assign expired = en && (count_q == LAST);

endmodule

// File: rtl/cmd_framer.sv
// ----------------------------------------------------------------------------
// cmd_framer
// Slave-side command framer. Pairs received UART bytes into 16-bit commands
// (high byte first) for the dispatcher, discards a half command after an
// inter-byte timeout, and sends dispatcher response bytes through the UART
// transmitter. The RX and TX machines run independently.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : cmd_framer_if.slave
//         rx_rdy/rx_data/clr_rx_rdy    UART receive handshake
//         cmd/cmd_rdy/clr_cmd_rdy      command to dispatcher
//         timeout                      pulse on half-command discard
//         resp/send_resp               response request from dispatcher
//         trmt/tx_data/tx_done         UART transmit handshake
//         tx_busy/resp_sent            response status
// ----------------------------------------------------------------------------
module cmd_framer
  import comm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  cmd_framer_if.slave  bus
);

  // --------------------------------------------------------------------------
  // RX side
  // --------------------------------------------------------------------------
  rx_state_t         rx_state_q, rx_state_d;
  logic [BYTE_W-1:0] high_q, high_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              timeout_q, timeout_d;
  logic              timer_clr, timer_en, timer_expired;
  logic              accepting;

  // Bytes are only taken while waiting for one; in FULL they stay in the UART.
  assign accepting  = (rx_state_q == WAIT_HIGH) || (rx_state_q == WAIT_LOW);
  assign timer_clr  = (rx_state_q == WAIT_HIGH) && bus.rx_rdy;
  assign timer_en   = (rx_state_q == WAIT_LOW);

  frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // A received low byte takes priority over the timer expiring in the same
  // cycle. The clearing cycle of FULL never consumes a byte because the
  // byte-consume strobe only looks at the current state.
  always_comb begin
    rx_state_d = rx_state_q;
    high_d     = high_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    timeout_d  = 1'b0;
    unique case (rx_state_q)
      WAIT_HIGH: begin
        if (bus.rx_rdy) begin
          high_d     = bus.rx_data;
          rx_state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (bus.rx_rdy) begin
          cmd_d      = {high_q, bus.rx_data};
          cmd_rdy_d  = 1'b1;
          rx_state_d = FULL;
        end else if (timer_expired) begin
          high_d     = '0;
          timeout_d  = 1'b1;
          rx_state_d = WAIT_HIGH;
        end
      end
      FULL: begin
        if (bus.clr_cmd_rdy) begin
          cmd_rdy_d  = 1'b0;
          rx_state_d = WAIT_HIGH;
        end
      end
      default: rx_state_d = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= WAIT_HIGH;
      high_q     <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      high_q     <= high_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.clr_rx_rdy = accepting && bus.rx_rdy;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.timeout    = timeout_q;

  // --------------------------------------------------------------------------
  // TX side
  // --------------------------------------------------------------------------
  tx_state_t         tx_state_q, tx_state_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              resp_sent_q, resp_sent_d;

  // send_resp is only looked at in TX_IDLE, so a request while busy is
  // dropped rather than queued; likewise tx_done only matters in TX_WAIT.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_data_d   = tx_data_q;
    resp_sent_d = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (bus.send_resp) begin
          tx_data_d  = bus.resp;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: tx_state_d = TX_WAIT;
      TX_WAIT: begin
        if (bus.tx_done) begin
          resp_sent_d = 1'b1;
          tx_state_d  = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_data_q   <= '0;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_data_q   <= tx_data_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign bus.trmt      = (tx_state_q == TX_SEND);
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_busy   = (tx_state_q != TX_IDLE);
  assign bus.resp_sent = resp_sent_q;

endmodule

// File: tb/tb_cmd_framer.sv
// ----------------------------------------------------------------------------
// tb_cmd_framer
// Directed self-checking bench for cmd_framer with TIMEOUT_CYCLES = 16.
// Inputs change 1 time unit after a rising edge; outputs are read 1-2 time
// units after that edge, well away from the next one.
// ----------------------------------------------------------------------------
module tb_cmd_framer;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  cmd_framer_if bus ();

  cmd_framer #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present one byte for one cycle, report the consume strobe seen in that
  // cycle, then drop rx_rdy the way the UART does after being cleared.
  task automatic send_byte(input logic [7:0] b, output logic clr_seen);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    #1;
    clr_seen = bus.clr_rx_rdy;
    tick();
    bus.rx_rdy = 1'b0;
  endtask

  task automatic clear_cmd();
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
  endtask

  // Reset values of every output.
  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    #1;
    vectors++; if (bus.cmd !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_cmd: got %h expected 0000", bus.cmd); end
    vectors++; if (bus.cmd_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cmd_rdy: got %b expected 0", bus.cmd_rdy); end
    vectors++; if (bus.timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_timeout: got %b expected 0", bus.timeout); end
    vectors++; if (bus.trmt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_trmt: got %b expected 0", bus.trmt); end
    vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    vectors++; if (bus.tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_busy: got %b expected 0", bus.tx_busy); end
    vectors++; if (bus.resp_sent !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp_sent: got %b expected 0", bus.resp_sent); end
    vectors++; if (bus.clr_rx_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_clr_rx_rdy: got %b expected 0", bus.clr_rx_rdy); end
  endtask

  // Two bytes ten cycles apart form 0xA53C.
  task automatic test_basic_frame();
    logic c;
    send_byte(8'hA5, c);
    vectors++; if (c !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_clr_high: got %b expected 1", c); end
    #1;
    vectors++; if (bus.clr_rx_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_clr_single: got %b expected 0", bus.clr_rx_rdy); end
    vectors++; if (bus.cmd_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_rdy_early: got %b expected 0", bus.cmd_rdy); end
    idle(9);
    send_byte(8'h3C, c);
    vectors++; if (c !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_clr_low: got %b expected 1", c); end
    vectors++; if (bus.cmd_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_cmd_rdy: got %b expected 1", bus.cmd_rdy); end
    vectors++; if (bus.cmd !== 16'hA53C) begin miscompares++; $display("[TB] FAIL basic_cmd: got %h expected a53c", bus.cmd); end
    clear_cmd();
    vectors++; if (bus.cmd_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_cleared: got %b expected 0", bus.cmd_rdy); end
  endtask

  // A lone high byte times out 16 edges after capture and is discarded.
  task automatic test_timeout();
    logic c;
    logic early;
    early = 1'b0;
    send_byte(8'h12, c);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.timeout !== 1'b0) early = 1'b1;
    end
    vectors++; if (early !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_early: got %b expected 0", early); end
    tick();
    vectors++; if (bus.timeout !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_pulse: got %b expected 1", bus.timeout); end
    tick();
    vectors++; if (bus.timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_one_cycle: got %b expected 0", bus.timeout); end
    vectors++; if (bus.cmd_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_no_cmd: got %b expected 0", bus.cmd_rdy); end
    send_byte(8'h34, c);
    send_byte(8'h56, c);
    vectors++; if (bus.cmd !== 16'h3456) begin miscompares++; $display("[TB] FAIL timeout_resync_cmd: got %h expected 3456", bus.cmd); end
    vectors++; if (bus.cmd_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_resync_rdy: got %b expected 1", bus.cmd_rdy); end
    clear_cmd();
  endtask

  // Low byte arriving in the timer == 15 cycle wins over the timeout.
  task automatic test_timer_boundary();
    logic c;
    send_byte(8'hEE, c);
    idle(15);
    vectors++; if (bus.timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL edge_no_early_timeout: got %b expected 0", bus.timeout); end
    send_byte(8'h99, c);
    vectors++; if (c !== 1'b1) begin miscompares++; $display("[TB] FAIL edge_clr: got %b expected 1", c); end
    vectors++; if (bus.timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL edge_timeout: got %b expected 0", bus.timeout); end
    vectors++; if (bus.cmd_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL edge_cmd_rdy: got %b expected 1", bus.cmd_rdy); end
    vectors++; if (bus.cmd !== 16'hEE99) begin miscompares++; $display("[TB] FAIL edge_cmd: got %h expected ee99", bus.cmd); end
  endtask

  // While FULL a pending byte waits; it becomes the next high byte only on
  // the cycle after the clear.
  task automatic test_full_hold();
    logic c;
    logic held;
    held = 1'b1;
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.clr_rx_rdy !== 1'b0 || bus.cmd !== 16'hEE99 || bus.cmd_rdy !== 1'b1) held = 1'b0;
      tick();
    end
    vectors++; if (held !== 1'b1) begin miscompares++; $display("[TB] FAIL full_hold: got %b expected 1", held); end
    bus.clr_cmd_rdy = 1'b1;
    #1;
    vectors++; if (bus.clr_rx_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL full_clear_cycle: got %b expected 0", bus.clr_rx_rdy); end
    tick();
    bus.clr_cmd_rdy = 1'b0;
    #1;
    vectors++; if (bus.cmd_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL full_rdy_cleared: got %b expected 0", bus.cmd_rdy); end
    vectors++; if (bus.clr_rx_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL full_next_consume: got %b expected 1", bus.clr_rx_rdy); end
    tick();
    bus.rx_rdy = 1'b0;
    send_byte(8'h01, c);
    vectors++; if (bus.cmd !== 16'h7701) begin miscompares++; $display("[TB] FAIL full_next_cmd: got %h expected 7701", bus.cmd); end
    clear_cmd();
  endtask

  // Response path: strobe, ignored second request, completion pulse.
  task automatic test_tx();
    logic quiet;
    bus.resp      = 8'hC3;
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    vectors++; if (bus.trmt !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_trmt: got %b expected 1", bus.trmt); end
    vectors++; if (bus.tx_data !== 8'hC3) begin miscompares++; $display("[TB] FAIL tx_data: got %h expected c3", bus.tx_data); end
    vectors++; if (bus.tx_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_busy: got %b expected 1", bus.tx_busy); end
    tick();
    vectors++; if (bus.trmt !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_trmt_single: got %b expected 0", bus.trmt); end
    bus.resp      = 8'h5A;
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bus.trmt !== 1'b0) quiet = 1'b0;
      tick();
    end
    vectors++; if (quiet !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_busy_ignored: got %b expected 1", quiet); end
    vectors++; if (bus.tx_data !== 8'hC3) begin miscompares++; $display("[TB] FAIL tx_data_kept: got %h expected c3", bus.tx_data); end
    vectors++; if (bus.resp_sent !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_sent_early: got %b expected 0", bus.resp_sent); end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    vectors++; if (bus.resp_sent !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_resp_sent: got %b expected 1", bus.resp_sent); end
    vectors++; if (bus.tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_idle: got %b expected 0", bus.tx_busy); end
    tick();
    vectors++; if (bus.resp_sent !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_sent_single: got %b expected 0", bus.resp_sent); end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    tick();
    vectors++; if (bus.resp_sent !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_stray_done: got %b expected 0", bus.resp_sent); end
  endtask

  // Reset with RX in WAIT_LOW and TX in TX_WAIT.
  task automatic test_reset_midstream();
    logic c;
    send_byte(8'hAB, c);
    bus.resp      = 8'h11;
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (bus.cmd !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_cmd: got %h expected 0000", bus.cmd); end
    vectors++; if (bus.tx_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_tx_busy: got %b expected 0", bus.tx_busy); end
    vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_tx_data: got %h expected 00", bus.tx_data); end
    vectors++; if (bus.trmt !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_trmt: got %b expected 0", bus.trmt); end
    vectors++; if (bus.cmd_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_cmd_rdy: got %b expected 0", bus.cmd_rdy); end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    tick();
    vectors++; if (bus.resp_sent !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_stray_done: got %b expected 0", bus.resp_sent); end
    send_byte(8'h5A, c);
    send_byte(8'hC0, c);
    vectors++; if (bus.cmd !== 16'h5AC0) begin miscompares++; $display("[TB] FAIL rst_clean_cmd: got %h expected 5ac0", bus.cmd); end
    vectors++; if (bus.cmd_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_clean_rdy: got %b expected 1", bus.cmd_rdy); end
    clear_cmd();
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst             = 1'b1;
    bus.rx_rdy      = 1'b0;
    bus.rx_data     = 8'h00;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp        = 8'h00;
    bus.send_resp   = 1'b0;
    bus.tx_done     = 1'b0;

    test_reset();
    test_basic_frame();
    test_timeout();
    test_timer_boundary();
    test_full_hold();
    test_tx();
    test_reset_midstream();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
